// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW systolic datapath: cost width, the
// saturated cost value and the score tracker state encoding.
package dtw_pkg;

    // Cost width common to the PE array and the score tracker.
    localparam int COST_WIDTH = 16;

    // Saturated (all ones) cost; also the "nothing seen yet" best value.
    localparam logic [COST_WIDTH-1:0] COST_MAX = '1;

    // Score tracker states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/dtw_score_tracker.sv
// Minimum-cost tracker behind the last PE of the DTW row. Accepts one
// accumulated cost per reference position, keeps the running minimum and
// the earliest index where it occurs, and hands a single result record
// (cost, position, threshold match) to the read-until logic on a
// valid/ready handshake.
module dtw_score_tracker
    import dtw_pkg::*;
#(
    parameter int width     = COST_WIDTH,
    parameter int idx_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [idx_width-1:0] ref_len,
    input  logic [width-1:0]     threshold,
    input  logic                 in_valid,
    input  logic [width-1:0]     in_cost,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [width-1:0]     res_cost,
    output logic [idx_width-1:0] res_pos,
    output logic                 res_match
);

    state_t state, state_next;

    logic [idx_width-1:0] len_q;
    logic [width-1:0]     thr_q;
    logic [idx_width-1:0] count;
    logic [width-1:0]     best_cost;
    logic [idx_width-1:0] best_pos;

    logic                 take;
    logic                 last;
    logic                 better;
    logic [width-1:0]     cand_cost;
    logic [idx_width-1:0] cand_pos;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; start only counts in IDLE, inputs ignored in HOLD.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        case (state)
            ST_IDLE: if (start)          state_next = (ref_len == '0) ? ST_HOLD : ST_RUN;
            ST_RUN:  if (take && last)   state_next = ST_HOLD;
            ST_HOLD: if (res_ready)      state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    // Running-minimum candidate; strict compare keeps the earliest index on ties.
    always_comb begin
        take      = (state == ST_RUN) && in_valid;
        last      = (count == len_q - 1'b1);
        better    = (in_cost < best_cost);
        cand_cost = better ? in_cost : best_cost;
        cand_pos  = better ? count   : best_pos;
    end

    // Scan datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_cost  <= '0;
            res_pos   <= '0;
            res_match <= 1'b0;
            count     <= '0;
            len_q     <= '0;
            thr_q     <= '0;
            best_cost <= '1;
            best_pos  <= '0;
        end else begin
            busy      <= (state_next != ST_IDLE);
            res_valid <= (state_next == ST_HOLD);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (ref_len == '0) begin
                            // Empty scan: publish the "no match" record directly.
                            res_cost  <= '1;
                            res_pos   <= '0;
                            res_match <= 1'b0;
                        end else begin
                            len_q     <= ref_len;
                            thr_q     <= threshold;
                            best_cost <= '1;
                            best_pos  <= '0;
                            count     <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (take) begin
                        best_cost <= cand_cost;
                        best_pos  <= cand_pos;
                        count     <= count + 1'b1;
                        if (last) begin
                            // Final sample is folded in before publishing.
                            res_cost  <= cand_cost;
                            res_pos   <= cand_pos;
                            res_match <= (cand_cost <= thr_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_score_tracker.sv
// Self-checking bench for dtw_score_tracker: directed scans, a queue-based
// reference model checked every cycle, and literal expectations per scan.
module tb_dtw_score_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] ref_len;
    logic [15:0] threshold;
    logic        in_valid;
    logic [15:0] in_cost;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_cost;
    logic [15:0] res_pos;
    logic        res_match;

    int vectors     = 0;
    int miscompares = 0;

    dtw_score_tracker #(.width(16), .idx_width(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_len   (ref_len),
        .threshold (threshold),
        .in_valid  (in_valid),
        .in_cost   (in_cost),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_cost  (res_cost),
        .res_pos   (res_pos),
        .res_match (res_match)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = waiting for start, 1 = collecting costs, 2 = result offered
    int          phase     = 0;
    int          target    = 0;
    logic [15:0] thr_m     = '0;
    logic [15:0] costs[$];
    logic        exp_busy  = 1'b0;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_cost  = '0;
    logic [15:0] exp_pos   = '0;
    logic        exp_match = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            phase = 0;
            costs.delete();
            exp_cost  = '0;
            exp_pos   = '0;
            exp_match = 1'b0;
        end else begin
            case (phase)
                0: if (start) begin
                    if (ref_len == 0) begin
                        phase     = 2;
                        exp_cost  = 16'hFFFF;
                        exp_pos   = 0;
                        exp_match = 1'b0;
                    end else begin
                        phase  = 1;
                        target = int'(ref_len);
                        thr_m  = threshold;
                        costs.delete();
                    end
                end
                1: if (in_valid) begin
                    costs.push_back(in_cost);
                    if (costs.size() == target) begin
                        exp_cost = costs[0];
                        exp_pos  = 0;
                        for (int i = 1; i < costs.size(); i++)
                            if (costs[i] < exp_cost) begin
                                exp_cost = costs[i];
                                exp_pos  = 16'(i);
                            end
                        exp_match = (exp_cost <= thr_m);
                        phase     = 2;
                    end
                end
                default: if (res_ready) phase = 0;
            endcase
        end
        exp_busy  = (phase != 0);
        exp_valid = (phase == 2);
    end

    // Compare process: outputs only move at posedge, so negedge is race free.
    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        check("res_valid", {31'd0, res_valid}, {31'd0, exp_valid});
        if (phase != 1) begin
            check("res_cost", {16'd0, res_cost}, {16'd0, exp_cost});
            check("res_pos", {16'd0, res_pos}, {16'd0, exp_pos});
            check("res_match", {31'd0, res_match}, {31'd0, exp_match});
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_scan(input logic [15:0] len, input logic [15:0] thr);
        @(negedge clk);
        start = 1'b1; ref_len = len; threshold = thr; in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] c);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_cost = c;
    endtask

    task automatic gap();
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("hs_valid_low", {31'd0, res_valid}, 32'd0);
        check("hs_busy_low", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] c,
                                input logic [15:0] p, input logic m);
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_cost"}, {16'd0, res_cost}, {16'd0, c});
        check({tag, "_pos"}, {16'd0, res_pos}, {16'd0, p});
        check({tag, "_match"}, {31'd0, res_match}, {31'd0, m});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ref_len = '0; threshold = '0;
        in_valid = 1'b0; in_cost = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_cost", {16'd0, res_cost}, 32'd0);

        // Normal scan, earliest tie wins.
        start_scan(16'd5, 16'd20);
        send(16'd50); send(16'd30); send(16'd12); send(16'd40); send(16'd12);
        gap();
        check_result("s1", 16'd12, 16'd2, 1'b1);
        handshake();

        // Gapped input.
        start_scan(16'd4, 16'd5);
        send(16'd9); gap(); gap(); gap();
        send(16'd7); gap();
        send(16'd8); send(16'd6);
        gap();
        check_result("s2", 16'd6, 16'd3, 1'b0);

        // Backpressure: hold with in_valid and start both asserted.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b1; ref_len = 16'd0; in_valid = 1'b1; in_cost = 16'd0;
        end
        check_result("s3_hold", 16'd6, 16'd3, 1'b0);
        @(negedge clk);
        res_ready = 1'b1; start = 1'b1; ref_len = 16'd2; in_valid = 1'b0;
        @(negedge clk);
        res_ready = 1'b0; start = 1'b0;
        check("s3_idle_valid", {31'd0, res_valid}, 32'd0);
        check("s3_idle_busy", {31'd0, busy}, 32'd0);
        gap();
        check("s3_start_ignored", {31'd0, busy}, 32'd0);
        check("s3_res_kept", {16'd0, res_cost}, 32'd6);

        // Zero-length scan.
        start_scan(16'd0, 16'hFFFF);
        gap();
        check_result("s4_zero", 16'hFFFF, 16'd0, 1'b0);
        handshake();

        // Saturated costs never replace the initial best.
        start_scan(16'd3, 16'hFFFF);
        send(16'hFFFF); send(16'hFFFF); send(16'hFFFF);
        gap();
        check_result("s4_sat", 16'hFFFF, 16'd0, 1'b1);
        handshake();

        // Reset mid-scan discards everything.
        start_scan(16'd8, 16'd50);
        send(16'd10); send(16'd20); send(16'd30); send(16'd40);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("s5_rst_busy", {31'd0, busy}, 32'd0);
        check("s5_rst_valid", {31'd0, res_valid}, 32'd0);
        check("s5_rst_cost", {16'd0, res_cost}, 32'd0);
        check("s5_rst_pos", {16'd0, res_pos}, 32'd0);
        start_scan(16'd2, 16'd0);
        send(16'd3); send(16'd1);
        gap();
        check_result("s5_new", 16'd1, 16'd1, 1'b0);

        // Back-to-back: start right after the handshake, equality matches.
        handshake();
        start_scan(16'd1, 16'd100);
        send(16'd100);
        gap();
        check_result("s6", 16'd100, 16'd0, 1'b1);
        handshake();

        gap(); gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dtw_score_tracker.md
Name: dtw_score_tracker

Overview:
Downstream consumer of the last processing element in the DTW systolic row. It accepts one accumulated DTW cost per reference position. It tracks the minimum cost and the reference index where that minimum occurs, which gives the subsequence-DTW end point. After the final reference sample it presents a single result record (cost, position, threshold match) on a valid/ready handshake to the read-until decision logic.

Parameters:
- width, 16, cost data width; matches the PE cost width.
- idx_width, 16, reference index / length width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  begin new scan; sampled only in IDLE.
- ref_len  in  idx_width  number of costs in this scan; latched on accepted start.
- threshold  in  width  match threshold; latched on accepted start.
- in_valid  in  1  in_cost valid this cycle.
- in_cost  in  width  DTW cost from last PE, unsigned.
- busy  out  1  high in RUN and HOLD.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_cost  out  width  minimum cost of scan.
- res_pos  out  idx_width  index (0-based) of minimum.
- res_match  out  1  res_cost <= threshold.

Behaviour:
- Reset: rst synchronous, active-high; clock clk.
  - On reset: state=IDLE; busy, res_valid, res_cost, res_pos, res_match = 0; count=0.
  - rst mid-scan discards the scan entirely; no partial result is produced.
- States: IDLE, RUN, HOLD. All outputs are registered.
- IDLE:
  - start=1 with ref_len!=0: latch ref_len and threshold; best_cost <= all ones; best_pos <= 0; count <= 0; go to RUN.
  - start=1 with ref_len==0: go directly to HOLD with res_cost=all ones, res_pos=0, res_match=0.
  - in_valid is ignored in IDLE.
- RUN:
  - Each cycle with in_valid=1:
    - If in_cost < best_cost (strict), then best_cost <= in_cost and best_pos <= count. Ties keep the earliest index.
    - count <= count+1.
  - in_valid=0 cycles leave all state unchanged; gaps of any length are allowed.
  - When in_valid=1 and count==ref_len-1:
    - Go to HOLD next cycle.
    - The comparison includes that final sample.
    - res_match is computed from the final best value against the latched threshold.
    - res_valid=1 in the cycle after the last accepted sample (latency 1).
  - start is ignored in RUN.
- HOLD:
  - res_valid=1; res_cost, res_pos and res_match are held stable.
  - in_valid and start are ignored.
  - res_ready=1 completes the handshake: next cycle is IDLE with res_valid=0. Result outputs keep their values until the next start.
  - A start in the same cycle as the handshake is ignored; start must be reasserted in IDLE.
- Arithmetic:
  - Unsigned compare only.
  - An all-ones input (saturated cost) is a legal value; it never replaces an initial best of all ones.
  - count never wraps, because the scan terminates at ref_len-1.
  - ref_len = 2^idx_width-1 is the maximum scan length.

Decomposition:
- Shared package dtw_pkg holds:
  - state encoding localparams ST_IDLE/ST_RUN/ST_HOLD;
  - COST_MAX (all ones, width bits);
  - default width 16, common with the PE array.
- No sub-module is required. The compare/update is a few lines of inline logic. dtw_pe_row instantiates this block after its last PE.

Test Plan:
- Normal scan, in-range minimum:
  - Stimulus: rst; start, ref_len=5, threshold=20; costs 50,30,12,40,12 back-to-back.
  - Response: res_valid one cycle after the 5th sample; res_cost=12, res_pos=2 (earliest tie wins), res_match=1.
- Gapped input:
  - Stimulus: ref_len=4, threshold=5; costs 9 (gap 3 cycles) 7 (gap 1) 8, 6.
  - Response: res_cost=6, res_pos=3, res_match=0; busy high throughout until the handshake.
- Backpressure and ignored inputs:
  - Stimulus: hold res_ready=0 for 10 cycles while driving in_valid=1 and start=1.
  - Response: outputs stable, no state change. res_ready=1 then gives IDLE and res_valid=0 next cycle; the same-cycle start is ignored.
- Zero-length and saturated scans:
  - ref_len=0 -> HOLD next cycle; res_cost=0xFFFF, res_pos=0, res_match=0.
  - ref_len=3 with all costs 0xFFFF -> res_cost=0xFFFF, res_pos=0.
- Reset mid-scan:
  - Stimulus: ref_len=8; after 4 samples assert rst for 1 cycle.
  - Response: all outputs 0, IDLE. A new start with ref_len=2, costs 3,1 yields res_cost=1, res_pos=1 with no carry-over.
- Back-to-back scans:
  - Stimulus: complete the handshake, then start the next cycle with ref_len=1, cost 100, threshold=100.
  - Response: res_cost=100, res_pos=0, res_match=1 (equality matches).
